// File: rtl/branch_pc_sequencer_pkg.sv
// branch_pc_sequencer_pkg: branch type and FSM state encodings plus the PC defaults.
package branch_pc_sequencer_pkg;
    localparam int          PC_WIDTH_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JUMP = 2'b11
    } br_type_e;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CALC    = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    function automatic logic br_taken(input logic [1:0] typ, input logic zero);
        return (typ == BR_JUMP) || (typ == BR_BEQ && zero) || (typ == BR_BNE && !zero);
    endfunction
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: sign-extends a PC-relative byte offset and adds it to a base PC.
module branch_target_adder #(
    parameter int PC_WIDTH  = 16,
    parameter int OFF_WIDTH = 13
) (
    input  logic [PC_WIDTH-1:0]  i_base,
    input  logic [OFF_WIDTH-1:0] i_off,
    output logic [PC_WIDTH-1:0]  o_sum
);
    logic [PC_WIDTH-1:0] w_sext;
    assign w_sext = {{(PC_WIDTH-OFF_WIDTH){i_off[OFF_WIDTH-1]}}, i_off};
    assign o_sum  = i_base + w_sext;
endmodule

// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer: IDLE/CALC/RESOLVE PC sequencer committing branch targets on the ALU zero flag.
// Define BRANCH_STATS_EN to add the branch_count/branch_total statistics outputs.
module branch_pc_sequencer
    import branch_pc_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH  = PC_WIDTH_DEF,
    parameter int                  OFF_WIDTH = 13,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_PC_DEF)
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [OFF_WIDTH-1:0] offset_sh,
    input  logic [1:0]           br_type,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 cond_zero,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  target,
    output logic                 busy,
    output logic                 done,
`ifdef BRANCH_STATS_EN
    output logic [15:0]          branch_count,
    output logic [15:0]          branch_total,
`endif
    output logic                 taken
);
    logic [1:0]           r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_target;
    logic [OFF_WIDTH-1:0] r_off;
    logic [1:0]           r_type;
    logic                 r_done;
    logic                 r_taken;
    logic [PC_WIDTH-1:0]  w_target;
    logic                 w_tk;
    logic                 w_commit;

    branch_target_adder #(.PC_WIDTH(PC_WIDTH), .OFF_WIDTH(OFF_WIDTH)) u_adder (
        .i_base (r_pc),
        .i_off  (r_off),
        .o_sum  (w_target)
    );

    assign w_tk     = br_taken(r_type, cond_zero);
    assign w_commit = (r_state == ST_RESOLVE) && !stall;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_target <= '0;
            r_off    <= '0;
            r_type   <= '0;
            r_done   <= 1'b0;
            r_taken  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start && !stall) begin
                    r_off   <= offset_sh;
                    r_type  <= br_type;
                    r_pc    <= r_pc + PC_WIDTH'(2);
                    r_state <= ST_CALC;
                end
                // r_pc already holds the sequential PC here, so the target is PC+2+offset
                ST_CALC: begin
                    r_target <= w_target;
                    r_state  <= ST_RESOLVE;
                end
                ST_RESOLVE: if (!stall) begin
                    if (w_tk) r_pc <= r_target;
                    r_taken <= w_tk;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] r_count;
    logic [15:0] r_total;
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_count <= '0;
            r_total <= '0;
        end else if (w_commit) begin
            if (w_tk) r_count <= r_count + 16'd1;
            if (r_type != BR_NONE) r_total <= r_total + 16'd1;
        end
    end
    assign branch_count = r_count;
    assign branch_total = r_total;
`endif

    assign pc     = r_pc;
    assign target = r_target;
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign taken  = r_taken;
endmodule

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
- Multicycle program-counter sequencer sitting directly downstream of the 12→13-bit branch-offset left-shifter.
- Consumes the shifted byte offset and owns the architectural PC register.
- Per instruction: advances PC by 2, computes the branch/jump target as PC+2+sext(offset), and conditionally commits the target once the ALU zero flag is valid.
- Feeds instruction-memory address and fetch control.

Parameters:
- PC_WIDTH, 16, width of PC and target registers.
- OFF_WIDTH, 13, width of shifted offset input (bit 0 always 0).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- offset_sh  input  OFF_WIDTH  shifted offset from shifter, two's complement.
- br_type  input  2  00 none, 01 beq, 10 bne, 11 jump; sampled with start.
- start  input  1  new instruction decoded; accepted only in IDLE with stall=0.
- stall  input  1  freezes the FSM in IDLE or RESOLVE (memory/ALU not ready).
- cond_zero  input  1  ALU zero flag; valid while in RESOLVE.
- pc  output  PC_WIDTH  current PC register.
- target  output  PC_WIDTH  last computed target register.
- busy  output  1  high in CALC and RESOLVE.
- done  output  1  one-cycle pulse when the PC update commits.
- taken  output  1  registered; valid with done, holds until next done.

Behaviour:
- Reset (async, RST_n=0): pc=RESET_PC, target=0, busy=0, done=0, taken=0, state=IDLE, internal offset/type regs=0. Reset asserted mid-operation aborts the instruction with no partial PC update.
- States: IDLE, CALC, RESOLVE.
- IDLE:
  - start=1 and stall=0: latch offset_sh and br_type; pc<=pc+2; go CALC.
  - stall=1: start is ignored (no capture).
- CALC: target <= pc + sext16(offset_r), where pc is already +2. Addition is modulo 2^PC_WIDTH: wrap allowed, no overflow flag. Unconditionally go RESOLVE.
- RESOLVE:
  - stall=1: hold state; done=0.
  - Otherwise evaluate tk = (type==jump) | (type==beq & cond_zero) | (type==bne & ~cond_zero). type==none gives tk=0.
  - If tk: pc<=target. Always: taken<=tk, done pulses 1 cycle, go IDLE.
- Latency with no stall: start accepted at edge N → done high during cycle N+2 → new pc visible cycle N+3.
- start while busy: ignored, not queued.
- done and start may coincide in time only via back-to-back operation: start can be accepted in the first IDLE cycle after done.
- Offset bit 0 is ignored by neither path: it is used as-is, so the target is odd only if the upstream stage violates its contract. Targets are not checked.
- Offset extremes: 13'h0FFE → +4094; 13'h1000 → −4096.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds output branch_count (16 bits, reset 0), incremented on every done with taken=1, wrapping at 16'hFFFF→0.
  - Adds output branch_total (16 bits), incremented on every done with br_type≠none.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - br_type encodings BR_NONE/BR_BEQ/BR_BNE/BR_JUMP;
  - state encodings ST_IDLE/ST_CALC/ST_RESOLVE;
  - PC_WIDTH default;
  - RESET_PC.
- One natural sub-module: branch_target_adder (combinational sign-extend 13→16 plus 16-bit add). It is reused by any later PC-relative load logic. The FSM and registers stay in the top.

Test Plan:
- Reset with pc preloaded: RST_n low mid-CALC → pc=0000, busy=0, done=0 immediately (async), FSM in IDLE after release.
- pc=0x0010, br_type=beq, offset_sh=0x0008, cond_zero=1, no stall → done at cycle +2, taken=1, pc=0x001A.
- Same but cond_zero=0 → taken=0, pc=0x0012, target=0x001A.
- pc=0x0002, br_type=jump, offset_sh=0x1000 (−4096) → target=0xF004 (wrap), pc=0xF004.
- bne with stall held 3 cycles in RESOLVE: cond_zero=1 while stalled, then 0 on release → evaluated only on release, taken=1. start pulses during busy are ignored.
- BRANCH_STATS_EN: 3 beq (2 taken) + 1 none → branch_count=2, branch_total=3; without the macro, ports absent and build clean.
